// File: rtl/ander2_arb_pkg.sv
// Shared types and helpers for the ander2 round-robin arbiter.
package ander2_arb_pkg;

    // Controller states; the unused 2'd3 code is steered back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Width of a requester index; never less than one bit.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ander2.sv
// Single-bit two-input AND cell; one instance per datapath bit.
module ander2 (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a & b;

endmodule

// File: rtl/ander2_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import ander2_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    int             cand;
    logic [ID_W-1:0] cand_idx;

    // Walk ptr, ptr+1, ... modulo N_REQ and keep the first requester found.
    // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand     = (int'(ptr) + k) % N_REQ;
            cand_idx = ID_W'(cand);
            if (!any && req[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
                any             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ander2_arbiter.sv
// Time-shares one bank of ander2 cells among N_REQ requesters with
// round-robin arbitration and a tagged valid/ready result port.
module ander2_arbiter
    import ander2_arb_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = 1,
    localparam int ID_W   = id_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_res,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy
);

    state_t             state;
    state_t             state_next;

    logic [ID_W-1:0]    ptr;
    logic [N_REQ-1:0]   pick_grant;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic               accept;

    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [ID_W-1:0]    op_id;
    logic [DATA_W-1:0]  and_out;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A request is taken only from IDLE, and never while reset is held.
    assign accept = (state == IDLE) && pick_any && !rst;

    // State register.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: IDLE -> EXEC on a grant, EXEC -> RESP, RESP -> IDLE on handshake.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = pick_any ? EXEC : IDLE;
            EXEC:    state_next = RESP;
            RESP:    state_next = rsp_ready ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; the grant strobe is visible only in IDLE.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    req_ready = pick_grant;
                end
            end
            EXEC: begin
                busy = 1'b1;
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // On acceptance, capture the winner's operands and tag, and advance the pointer past it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            op_id <= '0;
        end else if (accept) begin
            op_a  <= req_a[int'(pick_idx)*DATA_W +: DATA_W];
            op_b  <= req_b[int'(pick_idx)*DATA_W +: DATA_W];
            op_id <= pick_idx;
            ptr   <= (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    // Bitwise ander2 bank on the operand registers; no cross-bit logic.
    for (genvar k = 0; k < DATA_W; k++) begin : g_bank
        ander2 u_and (
            .a (op_a[k]),
            .b (op_b[k]),
            .y (and_out[k])
        );
    end

    // Register the result and tag in EXEC; they then hold through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_res <= '0;
            rsp_id  <= '0;
        end else if (state == EXEC) begin
            rsp_res <= and_out;
            rsp_id  <= op_id;
        end
    end

endmodule

// File: tb/tb_ander2_arbiter.sv
// Self-checking bench for ander2_arbiter: directed scenarios plus random
// traffic, checked against a transaction-level round-robin model.
module tb_ander2_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           rsp_ready = 1'b0;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [W-1:0]   rsp_res;
    logic [IW-1:0]  rsp_id;
    logic           busy;

    int n_cmp = 0;
    int n_err = 0;

    // Model: 0 = free, 1 = computing, 2 = result offered.
    int           m_stage = 0;
    int           m_ptr   = 0;
    logic [W-1:0] m_res   = '0;
    int           m_id    = 0;
    int           g_q[$];

    ander2_arbiter #(
        .N_REQ  (N),
        .DATA_W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One clock: drive at negedge, check 1ns later, advance the model for the next posedge.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] a,
                        input logic [N*W-1:0] b, input logic rr);
        logic [N-1:0] exp_ready;
        logic [IW-1:0] wi;
        int w;
        int c;
        @(negedge clk);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        #1;
        exp_ready = '0;
        w = -1;
        if (m_stage == 0) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (w < 0 && v[c[IW-1:0]]) w = c;
            end
        end
        if (w >= 0) begin
            wi = w[IW-1:0];
            exp_ready[wi] = 1'b1;
        end
        n_cmp++;
        if (req_ready !== exp_ready) begin
            n_err++;
            $display("FAIL req_ready t=%0t got=%b want=%b", $time, req_ready, exp_ready);
        end
        n_cmp++;
        if (rsp_valid !== (m_stage == 2)) begin
            n_err++;
            $display("FAIL rsp_valid t=%0t got=%b want=%b", $time, rsp_valid, (m_stage == 2));
        end
        n_cmp++;
        if (busy !== (m_stage != 0)) begin
            n_err++;
            $display("FAIL busy t=%0t got=%b want=%b", $time, busy, (m_stage != 0));
        end
        if (m_stage == 2) begin
            n_cmp++;
            if (rsp_res !== m_res || rsp_id !== IW'(m_id)) begin
                n_err++;
                $display("FAIL rsp_data t=%0t got res=%h id=%0d want res=%h id=%0d",
                         $time, rsp_res, rsp_id, m_res, m_id);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (req_ready[k] === 1'b1) g_q.push_back(k);
        end
        case (m_stage)
            0: if (w >= 0) begin
                m_res   = a[w*W +: W] & b[w*W +: W];
                m_id    = w;
                m_ptr   = (w + 1) % N;
                m_stage = 1;
            end
            1: m_stage = 2;
            default: if (rr) m_stage = 0;
        endcase
    endtask

    // Asynchronous reset pulse, asserted away from the edge and released at a negedge.
    task automatic do_reset();
        req_valid = '1;
        #2;
        rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            #1;
            n_cmp++;
            if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
                rsp_res !== '0 || rsp_id !== '0) begin
                n_err++;
                $display("FAIL reset_outputs t=%0t got ready=%b valid=%b busy=%b res=%h id=%0d want all zero",
                         $time, req_ready, rsp_valid, busy, rsp_res, rsp_id);
            end
            if (r == 0) @(negedge clk);
        end
        rst       = 1'b0;
        req_valid = '0;
        m_stage   = 0;
        m_ptr     = 0;
    endtask

    task automatic check_grants(input string name, input int exp_g[]);
        n_cmp++;
        if (g_q.size() != exp_g.size()) begin
            n_err++;
            $display("FAIL %s grant_count got=%0d want=%0d", name, g_q.size(), exp_g.size());
        end else begin
            for (int i = 0; i < exp_g.size(); i++) begin
                n_cmp++;
                if (g_q[i] != exp_g[i]) begin
                    n_err++;
                    $display("FAIL %s grant[%0d] got=%0d want=%0d", name, i, g_q[i], exp_g[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        step('0, '0, '0, 1'b1);
    endtask

    task automatic test_single();
        do_reset();
        g_q.delete();
        step(4'b0001, 16'h0001, 16'h0001, 1'b1);
        step('0, '0, '0, 1'b1);
        step('0, '0, '0, 1'b1);
        n_cmp++;
        if (rsp_res !== 4'h1 || rsp_id !== 2'd0) begin
            n_err++;
            $display("FAIL single_result got res=%h id=%0d want res=1 id=0", rsp_res, rsp_id);
        end
        check_grants("single", '{0});
    endtask

    task automatic test_operands();
        logic [1:0] pairs [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
        g_q.delete();
        for (int p = 0; p < 4; p++) begin
            a = '0;
            b = '0;
            a[W] = pairs[p][1];
            b[W] = pairs[p][0];
            step(4'b0010, a, b, 1'b1);
            step('0, '0, '0, 1'b1);
            step('0, '0, '0, 1'b1);
        end
        check_grants("operands", '{1, 1, 1, 1});
    endtask

    task automatic test_all_requesting();
        do_reset();
        g_q.delete();
        for (int i = 0; i < 15; i++) begin
            step(4'b1111, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1);
        end
        check_grants("all_req", '{0, 1, 2, 3, 0});
    endtask

    task automatic test_stall();
        step(4'b0100, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(N'($urandom()), {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0);
        end
        step('0, '0, '0, 1'b1);
        step('0, '0, '0, 1'b0);
    endtask

    task automatic test_reset_exec();
        do_reset();
        step(4'b0001, 16'hFFFF, 16'hFFFF, 1'b1);
        step('0, '0, '0, 1'b1);
        do_reset();
        g_q.delete();
        step(4'b1001, 16'h5005, 16'h3003, 1'b1);
        step('0, '0, '0, 1'b1);
        step('0, '0, '0, 1'b1);
        check_grants("reset_exec", '{0});
    endtask

    task automatic test_wrap();
        do_reset();
        g_q.delete();
        step(4'b0100, 16'h0A00, 16'h0600, 1'b1);
        step('0, '0, '0, 1'b1);
        step('0, '0, '0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(4'b1001, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1);
        end
        check_grants("wrap", '{2, 3, 0, 3});
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(N'($urandom()), {$urandom(), $urandom()}, {$urandom(), $urandom()},
                 ($urandom_range(0, 3) != 0));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_operands();
        test_all_requesting();
        test_stall();
        test_reset_exec();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
